// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: operand forwarding, load-use stall, multi-cycle E-stage hold, flushes, perf counters.
// Latency: stall/flush/forward are combinational from inputs and FSM state; counters update on the next edge.
// Backpressure: a held multi-cycle op stalls F/D/E and bubbles M; a load-use stalls F/D and bubbles E.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              rs1_used_d,
    input  logic              rs2_used_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              mem_read_e,
    input  logic              mc_start_e,
    input  logic              pc_src_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              perf_clr,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic [CNT_W-1:0]  lw_stall_cnt,
    output logic [CNT_W-1:0]  mc_stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_t;

    // A single-cycle "multi-cycle" op never needs the BUSY state.
    localparam logic       MC_MULTI = (MC_LAT > 1);
    localparam logic [7:0] MC_LOAD  = (MC_LAT > 1) ? 8'(MC_LAT - 2) : 8'd0;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [7:0]       r_mc_cnt;
    logic [CNT_W-1:0] r_lw_cnt;
    logic [CNT_W-1:0] r_mc_cnt_perf;
    logic [CNT_W-1:0] r_fl_cnt;

    logic       w_mc_stall;
    logic       w_lw_stall;
    logic       w_flush_d;
    logic       w_flush_e;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // Memory stage result is younger than Writeback, so it wins a double match; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (rs != '0 && reg_write_m && rd_m == rs)
            return 2'b10;
        else if (rs != '0 && reg_write_w && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Hazard detection; mc_start_e is ignored in BUSY because it is the held op itself.
    always_comb begin
        w_fwd_a    = fwd_sel(rs1_e);
        w_fwd_b    = fwd_sel(rs2_e);
        w_lw_stall = valid_d & mem_read_e & (rd_e != '0) &
                     ((rs1_used_d & (rs1_d == rd_e)) | (rs2_used_d & (rs2_d == rd_e)));
        if (r_state == RUN)
            w_mc_stall = mc_start_e & MC_MULTI;
        else
            w_mc_stall = (r_mc_cnt != 8'd0);
        // The instruction held in E must never be killed, so a multi-cycle stall masks flushes.
        w_flush_e  = (w_lw_stall | pc_src_e) & ~w_mc_stall;
        w_flush_d  = pc_src_e & ~w_mc_stall;
    end

    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        stall_f    = rst_n & (w_lw_stall | w_mc_stall);
        stall_d    = rst_n & (w_lw_stall | w_mc_stall);
        stall_e    = rst_n & w_mc_stall;
        flush_m    = rst_n & w_mc_stall;
        flush_e    = rst_n & w_flush_e;
        flush_d    = rst_n & w_flush_d;
        forward_ae = rst_n ? w_fwd_a : 2'b00;
        forward_be = rst_n ? w_fwd_b : 2'b00;
    end

    // Multi-cycle occupancy FSM: RUN accepts a new op, BUSY counts down the remaining stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_mc_cnt <= 8'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (mc_start_e && MC_MULTI) begin
                        r_state  <= BUSY;
                        r_mc_cnt <= MC_LOAD;
                    end
                end
                BUSY: begin
                    if (r_mc_cnt != 8'd0)
                        r_mc_cnt <= r_mc_cnt - 8'd1;
                    else
                        r_state  <= RUN;
                end
                default: begin
                    r_state  <= RUN;
                    r_mc_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Saturating performance counters; clear takes priority over the same cycle's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lw_cnt      <= '0;
            r_mc_cnt_perf <= '0;
            r_fl_cnt      <= '0;
        end else if (perf_clr) begin
            r_lw_cnt      <= '0;
            r_mc_cnt_perf <= '0;
            r_fl_cnt      <= '0;
        end else begin
            if (w_lw_stall && !w_mc_stall && r_lw_cnt != '1)
                r_lw_cnt <= r_lw_cnt + CNT_ONE;
            if (w_mc_stall && r_mc_cnt_perf != '1)
                r_mc_cnt_perf <= r_mc_cnt_perf + CNT_ONE;
            if (w_flush_d && r_fl_cnt != '1)
                r_fl_cnt <= r_fl_cnt + CNT_ONE;
        end
    end

    assign lw_stall_cnt = r_lw_cnt;
    assign mc_stall_cnt = r_mc_cnt_perf;
    assign flush_cnt    = r_fl_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle sequences, random vs reference model.
// Latency: outputs checked mid-cycle, counters compared against a model updated at each rising edge.
// Backpressure: none; the bench drives every input each cycle.
module tb_hazard_ctrl;

    localparam int AW     = 5;
    localparam int LAT    = 4;
    localparam int CW     = 8;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_d, rs1_used_d, rs2_used_d;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          mem_read_e, mc_start_e, pc_src_e, reg_write_m, reg_write_w, perf_clr;
    logic          stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
    logic [1:0]    forward_ae, forward_be;
    logic [CW-1:0] lw_stall_cnt, mc_stall_cnt, flush_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: cycles the current multi-cycle op still occupies E after this one.
    int m_left, m_lw, m_mc, m_fl;

    hazard_ctrl #(.REG_AW(AW), .MC_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .mem_read_e(mem_read_e), .mc_start_e(mc_start_e), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .perf_clr(perf_clr), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .forward_ae(forward_ae),
        .forward_be(forward_be), .lw_stall_cnt(lw_stall_cnt), .mc_stall_cnt(mc_stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
        if (rs == 0) return 2'b00;
        if (reg_write_m && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_in();
        valid_d = 0; rs1_d = 0; rs2_d = 0; rs1_used_d = 0; rs2_used_d = 0;
        rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        mem_read_e = 0; mc_start_e = 0; pc_src_e = 0;
        reg_write_m = 0; reg_write_w = 0; perf_clr = 0;
    endtask

    // One clock cycle: compare every output against the model at the falling edge, advance model at rising edge.
    task automatic tick();
        logic e_mc, e_lw;
        @(negedge clk);
        if (!rst_n) begin m_left = 0; m_lw = 0; m_mc = 0; m_fl = 0; end
        e_mc = rst_n && ((m_left > 1) || (m_left == 0 && mc_start_e && LAT > 1));
        e_lw = rst_n && valid_d && mem_read_e && rd_e != 0 &&
               ((rs1_used_d && rs1_d == rd_e) || (rs2_used_d && rs2_d == rd_e));
        chk("stall_f", stall_f, e_lw || e_mc);
        chk("stall_d", stall_d, e_lw || e_mc);
        chk("stall_e", stall_e, e_mc);
        chk("flush_m", flush_m, e_mc);
        chk("flush_e", flush_e, rst_n && (e_lw || pc_src_e) && !e_mc);
        chk("flush_d", flush_d, rst_n && pc_src_e && !e_mc);
        chk("forward_ae", forward_ae, rst_n ? ref_fwd(rs1_e) : 2'b00);
        chk("forward_be", forward_be, rst_n ? ref_fwd(rs2_e) : 2'b00);
        chk("lw_stall_cnt", lw_stall_cnt, m_lw);
        chk("mc_stall_cnt", mc_stall_cnt, m_mc);
        chk("flush_cnt", flush_cnt, m_fl);
        @(posedge clk);
        if (rst_n) begin
            if (perf_clr) begin
                m_lw = 0; m_mc = 0; m_fl = 0;
            end else begin
                if (e_lw && !e_mc && m_lw < CMAX) m_lw++;
                if (e_mc && m_mc < CMAX) m_mc++;
                if (pc_src_e && !e_mc && m_fl < CMAX) m_fl++;
            end
            if (m_left > 0) m_left--;
            else if (mc_start_e) m_left = LAT - 1;
        end
        #1;
    endtask

    typedef struct {
        logic [AW-1:0] rs1_e, rs2_e, rd_m; logic rwm;
        logic [AW-1:0] rd_w; logic rww; logic vd;
        logic [AW-1:0] rs1_d, rs2_d; logic u1, u2, mr;
        logic [AW-1:0] rd_e; logic pc;
        logic [1:0] efa, efb; logic estl, efd, efe;
    } vec_t;

    initial begin
        vec_t tv[11];
        tv[0]  = '{5, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0};
        tv[1]  = '{5, 0, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0};
        tv[2]  = '{3, 4, 4, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0};
        tv[3]  = '{3, 3, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        tv[4]  = '{0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 1, 1, 7, 0, 2'b00, 2'b00, 1, 0, 1};
        tv[5]  = '{0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 1, 7, 0, 2'b00, 2'b00, 0, 0, 0};
        tv[6]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        tv[7]  = '{0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1, 7, 0, 2'b00, 2'b00, 0, 0, 0};
        tv[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1, 1};
        tv[9]  = '{0, 0, 0, 0, 0, 0, 1, 9, 0, 1, 0, 1, 9, 1, 2'b00, 2'b00, 1, 1, 1};
        tv[10] = '{0, 0, 0, 0, 0, 0, 1, 9, 0, 1, 0, 0, 9, 0, 2'b00, 2'b00, 0, 0, 0};

        m_left = 0; m_lw = 0; m_mc = 0; m_fl = 0;
        clear_in();
        rst_n = 0;
        mc_start_e = 1; pc_src_e = 1; rs1_e = 5; rd_m = 5; reg_write_m = 1;
        #2;
        chk("reset_stall_f", stall_f, 0);
        chk("reset_flush_d", flush_d, 0);
        chk("reset_fwd_a", forward_ae, 0);
        tick(); tick();
        @(posedge clk); #1;
        clear_in(); rst_n = 1;
        tick();

        // Vector table, all applied in RUN with no multi-cycle op.
        for (int i = 0; i < 11; i++) begin
            rs1_e = tv[i].rs1_e; rs2_e = tv[i].rs2_e; rd_m = tv[i].rd_m; reg_write_m = tv[i].rwm;
            rd_w = tv[i].rd_w; reg_write_w = tv[i].rww; valid_d = tv[i].vd;
            rs1_d = tv[i].rs1_d; rs2_d = tv[i].rs2_d; rs1_used_d = tv[i].u1; rs2_used_d = tv[i].u2;
            mem_read_e = tv[i].mr; rd_e = tv[i].rd_e; pc_src_e = tv[i].pc;
            #2;
            chk($sformatf("vec%0d_fwd_a", i), forward_ae, tv[i].efa);
            chk($sformatf("vec%0d_fwd_b", i), forward_be, tv[i].efb);
            chk($sformatf("vec%0d_stall_d", i), stall_d, tv[i].estl);
            chk($sformatf("vec%0d_stall_e", i), stall_e, 0);
            chk($sformatf("vec%0d_flush_d", i), flush_d, tv[i].efd);
            chk($sformatf("vec%0d_flush_e", i), flush_e, tv[i].efe);
            tick();
        end
        clear_in();

        // Multi-cycle op held in E for LAT cycles: LAT-1 stalls, never flushed.
        perf_clr = 1; tick(); perf_clr = 0;
        mc_start_e = 1;
        for (int i = 0; i < LAT; i++) begin
            #2;
            chk($sformatf("mc_stall_e_c%0d", i), stall_e, (i < LAT - 1) ? 1 : 0);
            chk($sformatf("mc_flush_e_c%0d", i), flush_e, 0);
            tick();
        end
        mc_start_e = 0;
        #2;
        chk("mc_stall_cnt_after", mc_stall_cnt, LAT - 1);
        chk("mc_back_to_run", stall_e, 0);
        tick();

        // Branch during a held op is ignored; branch in RUN flushes and counts.
        mc_start_e = 1; tick();
        pc_src_e = 1; #2;
        chk("busy_flush_d", flush_d, 0);
        chk("busy_flush_e", flush_e, 0);
        tick();
        pc_src_e = 0; tick(); tick();
        mc_start_e = 0;
        perf_clr = 1; tick(); perf_clr = 0;
        pc_src_e = 1; #2;
        chk("run_flush_d", flush_d, 1);
        chk("run_flush_e", flush_e, 1);
        tick();
        pc_src_e = 0; #2;
        chk("run_flush_cnt", flush_cnt, 1);
        tick();

        // Reset in the middle of a multi-cycle stall.
        mc_start_e = 1; tick(); tick();
        rst_n = 0; #1;
        chk("rst_busy_stall_e", stall_e, 0);
        chk("rst_busy_stall_f", stall_f, 0);
        chk("rst_busy_mc_cnt", mc_stall_cnt, 0);
        tick();
        rst_n = 1; mc_start_e = 0; #2;
        chk("rst_release_run", stall_e, 0);
        tick(); tick();

        // Load-use counter saturation, then clear.
        valid_d = 1; mem_read_e = 1; rd_e = 7; rs2_d = 7; rs2_used_d = 1;
        repeat (CMAX + 5) tick();
        #2;
        chk("lw_cnt_sat", lw_stall_cnt, CMAX);
        tick();
        chk("lw_cnt_sat_hold", lw_stall_cnt, CMAX);
        perf_clr = 1; tick();
        clear_in(); #2;
        chk("lw_cnt_cleared", lw_stall_cnt, 0);
        tick();

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            valid_d     = 1'($urandom_range(0, 1));
            rs1_d       = 5'($urandom_range(0, 3));
            rs2_d       = 5'($urandom_range(0, 3));
            rs1_used_d  = 1'($urandom_range(0, 1));
            rs2_used_d  = 1'($urandom_range(0, 1));
            rs1_e       = 5'($urandom_range(0, 3));
            rs2_e       = 5'($urandom_range(0, 3));
            rd_e        = 5'($urandom_range(0, 3));
            rd_m        = 5'($urandom_range(0, 3));
            rd_w        = 5'($urandom_range(0, 3));
            reg_write_m = 1'($urandom_range(0, 1));
            reg_write_w = 1'($urandom_range(0, 1));
            mem_read_e  = 1'($urandom_range(0, 1));
            mc_start_e  = ($urandom_range(0, 5) == 0);
            pc_src_e    = ($urandom_range(0, 4) == 0);
            perf_clr    = ($urandom_range(0, 99) == 0);
            rst_n       = ($urandom_range(0, 149) != 0);
            tick();
        end
        rst_n = 1;
        clear_in();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
